rect_plotter: RTL and testbench

Parametrised rectangle drawing engine that sits between the game/control processor and `vga_adapter`. It replaces hand-sequenced per-pixel plotting. A single `start` request draws a filled rectangle, an outlined rectangle or a full-screen clear. It emits one pixel per clock on `xpos`/`ypos`/`colour_out`/`plot`, which connect directly to the adapter's `x`/`y`/`colour`/`plot` inputs. Rectangles are clipped to the screen and completion is reported with a `busy`/`done` handshake.

---
 rtl/rect_plotter.sv | 178 +++++++++++++++++
 tb/tb_rect_plotter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// Rectangle drawing engine: fills, outlines or clears a clipped screen region,
// presenting one registered pixel per clock to the VGA adapter.
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      xpos,
  output logic [Y_W-1:0]      ypos,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot
);

  typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;

  localparam logic [X_W-1:0] X_MAX_V = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_V = Y_W'(Y_MAX);
  localparam logic [X_W:0]   X_MAX_E = {1'b0, X_MAX_V};
  localparam logic [Y_W:0]   Y_MAX_E = {1'b0, Y_MAX_V};

  state_t state, next_state;

  logic [1:0]          req_mode;
  logic [X_W-1:0]      req_x0, req_w;
  logic [Y_W-1:0]      req_y0, req_h;
  logic [COLOUR_W-1:0] req_colour;

  logic [X_W-1:0] x_start, x_end, cur_x;
  logic [Y_W-1:0] y_start, y_end, cur_y;

  logic           is_outline, is_clear;
  logic [X_W:0]   x_last_full;
  logic [Y_W:0]   y_last_full;
  logic           region_empty;
  logic [X_W-1:0] clip_x_start, clip_x_end;
  logic [Y_W-1:0] clip_y_start, clip_y_end;

  logic           last_pixel, load_pixel, pix_hit;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;

  assign is_outline = (req_mode == 2'b01);
  assign is_clear   = (req_mode == 2'b10);

  // One extra bit keeps the far edge from wrapping near the coordinate limit.
  assign x_last_full = {1'b0, req_x0} + {1'b0, req_w} - 1'b1;
  assign y_last_full = {1'b0, req_y0} + {1'b0, req_h} - 1'b1;

  always_comb begin
    clip_x_start = req_x0;
    clip_y_start = req_y0;
    clip_x_end   = (x_last_full > X_MAX_E) ? X_MAX_V : x_last_full[X_W-1:0];
    clip_y_end   = (y_last_full > Y_MAX_E) ? Y_MAX_V : y_last_full[Y_W-1:0];
    region_empty = (req_w == '0) || (req_h == '0) ||
                   ({1'b0, req_x0} > X_MAX_E) || ({1'b0, req_y0} > Y_MAX_E);
    if (is_clear) begin
      clip_x_start = '0;
      clip_y_start = '0;
      clip_x_end   = X_MAX_V;
      clip_y_end   = Y_MAX_V;
      region_empty = 1'b0;
    end
  end

  assign last_pixel = (cur_x == x_end) && (cur_y == y_end);

  always_comb begin
    next_state = state;
    load_pixel = 1'b0;
    pix_x      = cur_x;
    pix_y      = cur_y;
    case (state)
      IDLE: if (start) next_state = CLIP;
      CLIP: begin
        if (region_empty) begin
          next_state = DONE;
        end else begin
          next_state = DRAW;
          load_pixel = 1'b1;
          pix_x      = clip_x_start;
          pix_y      = clip_y_start;
        end
      end
      DRAW: begin
        if (last_pixel) begin
          next_state = DONE;
        end else begin
          load_pixel = 1'b1;
          if (cur_x == x_end) begin
            pix_x = x_start;
            pix_y = cur_y + 1'b1;
          end else begin
            pix_x = cur_x + 1'b1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outline edges come from the unclipped rectangle, so clipped edges never match.
  always_comb begin
    pix_hit = 1'b1;
    if (is_outline)
      pix_hit = (pix_x == req_x0) || ({1'b0, pix_x} == x_last_full) ||
                (pix_y == req_y0) || ({1'b0, pix_y} == y_last_full);
  end

  assign busy = (state == CLIP) || (state == DRAW);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_mode   <= '0;
      req_x0     <= '0;
      req_y0     <= '0;
      req_w      <= '0;
      req_h      <= '0;
      req_colour <= '0;
      x_start    <= '0;
      y_start    <= '0;
      x_end      <= '0;
      y_end      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      xpos       <= '0;
      ypos       <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        req_mode   <= mode;
        req_x0     <= x0;
        req_y0     <= y0;
        req_w      <= w;
        req_h      <= h;
        req_colour <= colour;
      end
      if (state == CLIP) begin
        x_start <= clip_x_start;
        y_start <= clip_y_start;
        x_end   <= clip_x_end;
        y_end   <= clip_y_end;
      end
      plot <= 1'b0;
      if (load_pixel) begin
        cur_x <= pix_x;
        cur_y <= pix_y;
        if (pix_hit) begin
          xpos       <= pix_x;
          ypos       <= pix_y;
          colour_out <= req_colour;
          plot       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: checks pixel order, plot cycles, done timing,
// clipping, outline gating, busy interlock and asynchronous reset.
module tb_rect_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] mode;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour;
  logic       busy, done, plot;
  logic [7:0] xpos;
  logic [6:0] ypos;
  logic [2:0] colour_out;

  int compared   = 0;
  int mismatched = 0;

  int plot_xy[$];
  int plot_cyc[$];
  int exp_xy[$];
  int exp_cyc[$];
  int done_cycle, done_plot, done_busy, overlap, busy_gap, colour_bad;
  logic [2:0] exp_colour;

  rect_plotter dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .w(w), .h(h), .colour(colour),
    .busy(busy), .done(done), .xpos(xpos), .ypos(ypos),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clk = ~clk;

  function automatic int px(input int x, input int y);
    return x * 256 + y;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one request in cycle 0, then scrambles the inputs; returns in cycle 1.
  task automatic applyStimulus(input logic [1:0] m, input int xx0, input int yy0,
                               input int ww, input int hh, input logic [2:0] col);
    @(negedge clk);
    mode = m; x0 = 8'(xx0); y0 = 7'(yy0); w = 8'(ww); h = 7'(hh); colour = col;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m; x0 = 8'hAA; y0 = 7'h55; w = 8'd77; h = 7'd33; colour = ~col;
  endtask

  task automatic collect(input int limit, input int pulse_cycle);
    int  cycle;
    bit  finished;
    plot_xy.delete();
    plot_cyc.delete();
    done_cycle = -1; done_plot = -1; done_busy = -1;
    overlap = 0; busy_gap = 0; colour_bad = 0;
    cycle = 1;
    finished = 1'b0;
    while (!finished && cycle <= limit) begin
      if (busy && done) overlap++;
      if (!busy && !done) busy_gap++;
      if (plot) begin
        plot_xy.push_back(px(int'(xpos), int'(ypos)));
        plot_cyc.push_back(cycle);
        if (colour_out !== exp_colour) colour_bad++;
      end
      if (done) begin
        done_cycle = cycle;
        done_plot  = int'(plot);
        done_busy  = int'(busy);
        finished   = 1'b1;
      end else begin
        if (cycle == pulse_cycle) begin
          mode = 2'b00; x0 = 8'd1; y0 = 7'd1; w = 8'd1; h = 7'd1; start = 1'b1;
        end
        if (cycle == pulse_cycle + 1) start = 1'b0;
        @(negedge clk);
        cycle++;
      end
    end
  endtask

  task automatic checkRun(input string tag, input int exp_done);
    int bad_xy, bad_cyc, n;
    checkOutput({tag, "_done_cycle"}, done_cycle, exp_done);
    checkOutput({tag, "_done_plot"}, done_plot, 0);
    checkOutput({tag, "_done_busy"}, done_busy, 0);
    checkOutput({tag, "_busy_done_overlap"}, overlap, 0);
    checkOutput({tag, "_busy_gap"}, busy_gap, 0);
    checkOutput({tag, "_colour"}, colour_bad, 0);
    checkOutput({tag, "_plot_count"}, plot_xy.size(), exp_xy.size());
    bad_xy = 0; bad_cyc = 0;
    n = (plot_xy.size() < exp_xy.size()) ? plot_xy.size() : exp_xy.size();
    for (int i = 0; i < n; i++) begin
      if (plot_xy[i] != exp_xy[i]) bad_xy++;
      if (plot_cyc[i] != exp_cyc[i]) bad_cyc++;
    end
    if (n > 0) begin
      checkOutput({tag, "_pixel_coords"}, bad_xy, 0);
      checkOutput({tag, "_pixel_cycles"}, bad_cyc, 0);
    end
  endtask

  task automatic expectFill6;
    exp_xy  = '{px(10,5), px(11,5), px(12,5), px(10,6), px(11,6), px(12,6)};
    exp_cyc = '{2, 3, 4, 5, 6, 7};
    exp_colour = 3'b100;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mode = '0; x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_plot", plot, 0);
    checkOutput("reset_xpos", xpos, 0);
    checkOutput("reset_ypos", ypos, 0);
    checkOutput("reset_colour", colour_out, 0);
    resetn = 1'b1;
    @(negedge clk);

    expectFill6();
    applyStimulus(2'b00, 10, 5, 3, 2, 3'b100);
    collect(40, -1);
    checkRun("fill", 8);

    expectFill6();
    applyStimulus(2'b11, 10, 5, 3, 2, 3'b100);
    collect(40, -1);
    checkRun("reserved", 8);

    exp_xy  = '{px(158,118), px(159,118), px(158,119), px(159,119)};
    exp_cyc = '{2, 3, 4, 5};
    exp_colour = 3'b010;
    applyStimulus(2'b00, 158, 118, 4, 4, 3'b010);
    collect(40, -1);
    checkRun("clip", 6);

    exp_xy  = '{px(0,0), px(1,0), px(2,0), px(0,1), px(2,1), px(0,2), px(1,2), px(2,2)};
    exp_cyc = '{2, 3, 4, 5, 7, 8, 9, 10};
    exp_colour = 3'b111;
    applyStimulus(2'b01, 0, 0, 3, 3, 3'b111);
    collect(40, -1);
    checkRun("outline", 11);

    exp_xy.delete(); exp_cyc.delete();
    exp_colour = 3'b001;
    applyStimulus(2'b00, 10, 5, 0, 4, 3'b001);
    collect(20, -1);
    checkRun("empty_w0", 2);

    applyStimulus(2'b00, 200, 5, 5, 5, 3'b001);
    collect(20, -1);
    checkRun("empty_x200", 2);

    exp_xy.delete(); exp_cyc.delete();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        exp_xy.push_back(px(x, y));
        exp_cyc.push_back(2 + y * 160 + x);
      end
    exp_colour = 3'b000;
    applyStimulus(2'b10, 7, 9, 3, 3, 3'b000);
    collect(19300, 100);
    checkRun("clear", 19202);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("clear_no_queued_busy_%0d", i), busy, 0);
    end

    applyStimulus(2'b10, 0, 0, 0, 0, 3'b011);
    repeat (49) @(negedge clk);
    checkOutput("rst_pre_plot", plot, 1);
    resetn = 1'b0;
    #1;
    checkOutput("rst_plot", plot, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_idle_busy_%0d", i), busy, 0);
      checkOutput($sformatf("rst_idle_done_%0d", i), done, 0);
    end

    expectFill6();
    applyStimulus(2'b00, 10, 5, 3, 2, 3'b100);
    collect(40, -1);
    checkRun("fill_after_reset", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
